// File: rtl/seq_recorder_if.sv
// Step-input / RAM-write-output bundle for seq_recorder.
// The master side drives start/steps/commit; the slave side is the recorder.
interface seq_recorder_if #(
    parameter int unsigned ADDR_W = 7
);
    logic              start;
    logic              step_valid;
    logic [15:0]       step_data;
    logic              step_ready;
    logic              commit;
    logic [ADDR_W-1:0] wraddress;
    logic [31:0]       data;
    logic              wren;
    logic              busy;
    logic              done;
    logic              full;
    logic [ADDR_W:0]   word_count;

    modport master (
        output start, step_valid, step_data, commit,
        input  step_ready, wraddress, data, wren, busy, done, full, word_count
    );

    modport slave (
        input  start, step_valid, step_data, commit,
        output step_ready, wraddress, data, wren, busy, done, full, word_count
    );
endinterface

// File: rtl/seq_recorder.sv
// Packs pairs of 16-bit steps into 32-bit RAM words (first step in the low half).
// Optional SEQ_REC_CKSUM_EN appends an XOR checksum word at commit.
module seq_recorder #(
    parameter int unsigned ADDR_W    = 7,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic          CLK_50,
    input  logic          reset,
    seq_recorder_if.slave bus
);
    typedef enum logic [1:0] {IDLE, EMPTY, HALF, DONE} state_e;

    localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
    localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
    localparam logic [ADDR_W:0]   LIMIT    = (ADDR_W+1)'((1 << ADDR_W) - BASE_ADDR);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] wraddr_q, wraddr_d;
    logic [31:0]       data_q, data_d;
    logic              wren_q, wren_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              full_q, full_d;
    logic [15:0]       held_q, held_d;
`ifdef SEQ_REC_CKSUM_EN
    logic [31:0]       xor_q, xor_d;
    logic              cks_q, cks_d;
`endif

    logic              ready;
    logic              accept;
    logic              wr;
    logic [31:0]       wword;
    logic              closing;

    always_ff @(posedge CLK_50) begin
        if (reset) begin
            state_q  <= IDLE;
            addr_q   <= BASE;
            wraddr_q <= BASE;
            data_q   <= '0;
            wren_q   <= 1'b0;
            count_q  <= '0;
            full_q   <= 1'b0;
            held_q   <= '0;
`ifdef SEQ_REC_CKSUM_EN
            xor_q    <= '0;
            cks_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            wraddr_q <= wraddr_d;
            data_q   <= data_d;
            wren_q   <= wren_d;
            count_q  <= count_d;
            full_q   <= full_d;
            held_q   <= held_d;
`ifdef SEQ_REC_CKSUM_EN
            xor_q    <= xor_d;
            cks_q    <= cks_d;
`endif
        end
    end

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        wraddr_d = wraddr_q;
        data_d   = data_q;
        wren_d   = 1'b0;
        count_d  = count_q;
        full_d   = full_q;
        held_d   = held_q;
`ifdef SEQ_REC_CKSUM_EN
        xor_d    = xor_q;
        cks_d    = cks_q;
`endif
        accept   = bus.step_valid && ready;
        wr       = 1'b0;
        wword    = '0;
        closing  = 1'b0;

        if (bus.start) begin
            state_d = EMPTY;
            addr_d  = BASE;
            count_d = '0;
            full_d  = 1'b0;
            held_d  = '0;
`ifdef SEQ_REC_CKSUM_EN
            xor_d   = '0;
            cks_d   = 1'b0;
`endif
        end
`ifdef SEQ_REC_CKSUM_EN
        else if (cks_q) begin
            wr      = !full_q;
            wword   = xor_q;
            cks_d   = 1'b0;
            state_d = DONE;
        end
`endif
        else if (state_q == EMPTY || state_q == HALF) begin
            if (accept) begin
                if (state_q == HALF) begin
                    wr      = 1'b1;
                    wword   = {bus.step_data, held_q};
                    state_d = EMPTY;
                end else begin
                    held_d  = bus.step_data;
                    state_d = HALF;
                end
            end
            // A same-cycle step is folded in first, so commit sees the updated half.
            if (bus.commit) begin
                closing = 1'b1;
                if (state_d == HALF) begin
                    wr    = !full_q;
                    wword = {16'h0000, held_d};
                end
                state_d = EMPTY;
            end
        end

        if (wr) begin
            wren_d   = 1'b1;
            data_d   = wword;
            wraddr_d = addr_q;
            addr_d   = addr_q + ADDR_ONE;
            count_d  = count_q + CNT_ONE;
            full_d   = (count_q + CNT_ONE) == LIMIT;
`ifdef SEQ_REC_CKSUM_EN
            xor_d    = xor_q ^ wword;
`endif
        end

        if (closing) begin
`ifdef SEQ_REC_CKSUM_EN
            if (!full_d) begin
                cks_d = 1'b1;
            end else begin
                state_d = DONE;
            end
`else
            state_d = DONE;
`endif
        end
    end

    always_comb begin
        ready = (state_q == EMPTY || state_q == HALF) && !full_q;
`ifdef SEQ_REC_CKSUM_EN
        ready = ready && !cks_q;
`endif
        bus.step_ready = ready;
        bus.busy       = (state_q == EMPTY || state_q == HALF);
        bus.done       = (state_q == DONE);
        bus.full       = full_q;
        bus.word_count = count_q;
        bus.wraddress  = wraddr_q;
        bus.data       = data_q;
        bus.wren       = wren_q;
    end
endmodule

// File: tb/tb_seq_recorder.sv
// Scoreboard bench for seq_recorder: a step-level model predicts RAM writes and status.
module tb_seq_recorder;
    localparam int unsigned AW    = 7;
    localparam int unsigned BASE  = 0;
    localparam int unsigned LIMIT = (1 << AW) - BASE;
`ifdef SEQ_REC_CKSUM_EN
    localparam bit CKSUM = 1'b1;
`else
    localparam bit CKSUM = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    seq_recorder_if #(.ADDR_W(AW)) bus ();
    seq_recorder #(.ADDR_W(AW), .BASE_ADDR(BASE)) dut (
        .CLK_50(clk),
        .reset (rst),
        .bus   (bus)
    );

    typedef struct {
        int unsigned addr;
        logic [31:0] data;
        int unsigned due;
    } wr_t;

    wr_t         exp_q[$];
    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned cyc    = 0;
    bit          mon_en = 1'b0;

    // Recording model: steps are paired in arrival order, first step in the low half.
    bit          m_active, m_done, m_has_low, m_cks, m_full;
    logic [15:0] m_low;
    int unsigned m_words, m_next;
    logic [31:0] m_xor;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic void emit(input logic [31:0] w);
        wr_t e;
        e.addr = m_next;
        e.data = w;
        e.due  = cyc + 1;
        exp_q.push_back(e);
        m_next++;
        m_words++;
        m_xor  ^= w;
        m_full  = (m_words == LIMIT);
    endfunction

    function automatic void clear_rec();
        m_has_low = 1'b0;
        m_cks     = 1'b0;
        m_full    = 1'b0;
        m_words   = 0;
        m_next    = BASE;
        m_xor     = '0;
        m_done    = 1'b0;
    endfunction

    function automatic void model_step(input bit r, input bit st, input bit sv,
                                       input logic [15:0] sd, input bit cm);
        bit can_take = m_active && !m_cks && !m_full;
        if (r) begin
            clear_rec();
            m_active = 1'b0;
        end else if (st) begin
            clear_rec();
            m_active = 1'b1;
        end else if (m_cks) begin
            if (!m_full) emit(m_xor);
            m_cks    = 1'b0;
            m_active = 1'b0;
            m_done   = 1'b1;
        end else if (m_active) begin
            if (sv && can_take) begin
                if (m_has_low) begin
                    emit({sd, m_low});
                    m_has_low = 1'b0;
                end else begin
                    m_low     = sd;
                    m_has_low = 1'b1;
                end
            end
            if (cm) begin
                if (m_has_low && !m_full) emit({16'h0000, m_low});
                m_has_low = 1'b0;
                if (CKSUM && !m_full) begin
                    m_cks = 1'b1;
                end else begin
                    m_active = 1'b0;
                    m_done   = 1'b1;
                end
            end
        end
    endfunction

    task automatic tick(input bit r, input bit st, input bit sv, input logic [15:0] sd, input bit cm);
        @(negedge clk);
        if (mon_en) begin
            chk("step_ready", bus.step_ready, m_active && !m_cks && !m_full);
            chk("busy",       bus.busy,       m_active);
            chk("done",       bus.done,       m_done);
            chk("full",       bus.full,       m_full);
            chk("word_count", bus.word_count, m_words);
        end
        rst            = r;
        bus.start      = st;
        bus.step_valid = sv;
        bus.step_data  = sd;
        bus.commit     = cm;
        model_step(r, st, sv, sd, cm);
    endtask

    task automatic idle(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) tick(1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
    endtask

    task automatic step(input logic [15:0] sd, input bit cm);
        tick(1'b0, 1'b0, 1'b1, sd, cm);
    endtask

    always @(negedge clk) begin
        wr_t e;
        if (mon_en) begin
            while (exp_q.size() > 0 && exp_q[0].due < cyc) begin
                e = exp_q.pop_front();
                checks++;
                errors++;
                $display("FAIL missing_write: no wren for addr %0h data %0h due cycle %0d", e.addr, e.data, e.due);
            end
            if (bus.wren === 1'b1) begin
                if (exp_q.size() == 0 || exp_q[0].due != cyc) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious_write: wren=1 addr %0h data %0h, none expected (cycle %0d)",
                             bus.wraddress, bus.data, cyc);
                end else begin
                    e = exp_q.pop_front();
                    chk("wraddress", bus.wraddress, e.addr);
                    chk("wdata",     bus.data,      e.data);
                end
            end
        end
    end

    initial begin
        rst            = 1'b1;
        bus.start      = 1'b0;
        bus.step_valid = 1'b0;
        bus.step_data  = '0;
        bus.commit     = 1'b0;
        m_active       = 1'b0;
        m_low          = '0;
        clear_rec();

        tick(1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
        tick(1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
        mon_en = 1'b1;
        idle(1);
        chk("rst_wraddress", bus.wraddress, BASE);
        chk("rst_data",      bus.data,      32'h0);
        chk("rst_wren",      bus.wren,      1'b0);

        // Two steps then commit -> 32'hABCD1234 at address 0
        tick(1'b0, 1'b1, 1'b0, 16'h0, 1'b0);
        step(16'h1234, 1'b0);
        step(16'hABCD, 1'b0);
        tick(1'b0, 1'b0, 1'b0, 16'h0, 1'b1);
        idle(3);

        // Single step then commit -> zero-padded partial word
        tick(1'b0, 1'b1, 1'b0, 16'h0, 1'b0);
        step(16'h00FF, 1'b0);
        tick(1'b0, 1'b0, 1'b0, 16'h0, 1'b1);
        idle(3);

        // Second step accepted together with commit -> one full word only
        tick(1'b0, 1'b1, 1'b0, 16'h0, 1'b0);
        step(16'h0001, 1'b0);
        step(16'h0002, 1'b1);
        idle(3);

        // Step in empty slot with commit -> partial written immediately
        tick(1'b0, 1'b1, 1'b0, 16'h0, 1'b0);
        step(16'h5A5A, 1'b1);
        idle(3);

        // Words 0000FFFF and 00FF00FF (checksum 00FFFF00 when enabled)
        tick(1'b0, 1'b1, 1'b0, 16'h0, 1'b0);
        step(16'hFFFF, 1'b0);
        step(16'h0000, 1'b0);
        step(16'h00FF, 1'b0);
        step(16'h00FF, 1'b0);
        tick(1'b0, 1'b0, 1'b0, 16'h0, 1'b1);
        idle(3);

        // Fill the RAM with continuously valid steps; no wrap past the last word
        tick(1'b0, 1'b1, 1'b0, 16'h0, 1'b0);
        for (int unsigned i = 0; i < 2 * LIMIT + 6; i++) step(16'($urandom), 1'b0);
        chk("fill_full",       bus.full,       1'b1);
        chk("fill_count",      bus.word_count, LIMIT);
        chk("fill_last_addr",  bus.wraddress,  (1 << AW) - 1);
        chk("fill_step_ready", bus.step_ready, 1'b0);
        tick(1'b0, 1'b0, 1'b0, 16'h0, 1'b1);
        idle(3);

        // Reset while a low half is held -> nothing written, everything cleared
        tick(1'b0, 1'b1, 1'b0, 16'h0, 1'b0);
        step(16'h7777, 1'b0);
        tick(1'b1, 1'b0, 1'b1, 16'h8888, 1'b1);
        idle(3);
        chk("rst_mid_wren", bus.wren, 1'b0);

        // Reset wins over a same-cycle start
        tick(1'b1, 1'b1, 1'b0, 16'h0, 1'b0);
        idle(2);

        // Randomized traffic
        for (int unsigned i = 0; i < 4000; i++) begin
            tick($urandom_range(0, 299) == 0,
                 $urandom_range(0, 39) == 0,
                 $urandom_range(0, 9) < 7,
                 16'($urandom),
                 $urandom_range(0, 24) == 0);
        end
        idle(4);
        chk("queue_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/seq_recorder.md
SEQ_RECORDER -- requirements
Module: seq_recorder

Interface
REQ-001 The module SHALL have parameter ADDR_W, default 7, RAM write-address width (depth 2^ADDR_W words).
REQ-002 The module SHALL have parameter BASE_ADDR, default 0, first RAM word address written.
REQ-003 The module SHALL have port CLK_50  input  1  sole clock, rising edge.
REQ-004 The module SHALL have port reset  input  1  synchronous reset, active-high.
REQ-005 The module SHALL have port start  input  1  one-cycle pulse that opens a new recording.
REQ-006 The module SHALL have port step_valid  input  1  step offered.
REQ-007 The module SHALL have port step_data  input  16  step: [15:6] LED pattern, [5:0] hold ticks.
REQ-008 The module SHALL have port step_ready  output  1  step accepted when step_valid and step_ready are both high.
REQ-009 The module SHALL have port commit  input  1  one-cycle pulse that ends the recording.
REQ-010 The module SHALL have ports wraddress (output, ADDR_W), data (output, 32) and wren (output, 1) forming the RAM write port.
REQ-011 The module SHALL have ports busy, done and full (each output, 1) and word_count (output, ADDR_W+1, words written).

Function
REQ-012 States SHALL be IDLE, EMPTY (no half held), HALF (low half held), DONE.
REQ-013 start SHALL have effect in any state: it clears word_count, sets the address to BASE_ADDR, clears done and full, and moves to EMPTY.
REQ-014 step_ready SHALL be high only in EMPTY or HALF while full is low.
REQ-015 A step accepted in EMPTY SHALL be latched as the low half, and the FSM moves to HALF.
REQ-016 A step accepted in HALF SHALL drive, on the next cycle, a one-cycle wren with data={step,held_low} at the current address; the address then increments, word_count increments, and the FSM returns to EMPTY.
REQ-017 Write latency SHALL be exactly 1 cycle from the accepting edge to wren high; back-to-back steps at one per cycle SHALL be sustained.
REQ-018 commit in HALF SHALL write {16'h0000,held_low} the next cycle, then go to DONE; commit in EMPTY SHALL go to DONE with no write.
REQ-019 When step acceptance and commit occur in the same cycle, the step SHALL be processed first and then the commit, with any resulting partial word written one cycle after the full word.
REQ-020 full SHALL assert when word_count reaches 2^ADDR_W-BASE_ADDR; the address SHALL never wrap, and a step held in HALF at that point is discarded at commit.
REQ-021 commit and steps SHALL be ignored in IDLE and DONE.
REQ-022 busy SHALL be high in EMPTY and HALF; done SHALL be high in DONE.

Reset
REQ-023 reset SHALL force IDLE, wren=0, wraddress=BASE_ADDR, data=0, word_count=0, step_ready=0, busy=0, done=0, full=0, and SHALL discard any held half.
REQ-024 reset SHALL take priority over start, commit and steps in the same cycle; a reset mid-recording SHALL leave RAM contents already written untouched.

Configuration
REQ-025 With SEQ_REC_CKSUM_EN defined, commit SHALL append one extra word, the XOR of all data words written in this recording, one cycle after the last data write, counted in word_count, before DONE; if full, the checksum is omitted.
REQ-026 Without SEQ_REC_CKSUM_EN, no checksum logic SHALL exist and DONE follows the last data write directly.

Verification
REQ-027 reset, start, steps 16'h1234 then 16'hABCD, commit -> one wren, wraddress=0, data=32'hABCD1234, word_count=1, done=1.
REQ-028 start, step 16'h00FF, commit -> data=32'h000000FF at address 0, word_count=1.
REQ-029 start, 256 steps continuously valid -> 128 writes at addresses 0..127, full=1 after the 128th, step_ready=0, no wrap to 0.
REQ-030 start, step 16'h0001, then step 16'h0002 accepted in the same cycle as commit -> single write 32'h00020001, done=1.
REQ-031 SEQ_REC_CKSUM_EN defined, words 32'h0000FFFF and 32'h00FF00FF -> third write 32'h00FFFF00 at address 2, word_count=3.
REQ-032 reset asserted while in HALF -> wren stays 0, state IDLE, word_count=0, step_ready=0.
